kem_seq_ctrl: RTL and testbench
===============================

Name: kem_seq_ctrl

Overview:
- Top-level sequencer for the ML-KEM datapath.
- On a start request it selects keygen, encap or decap from a one-hot mode. It then issues one-cycle start pulses to the shared submodules (TRNG, sampleA, sampleCBD_2k, NTT, hashG) in a fixed order and waits for each module's done.
- Drives polynomial loop indices and NTT sub-mode; reports done, error (bad mode or timeout) and abort.
- Sits between the host command interface and the per-module engines.

Parameters:
K, 2, ML-KEM module rank; matrix is KxK.
TIMEOUT, 4096, maximum cycles to wait for a module done before flagging an error.
TO_W, 13, watchdog counter width; must be at least clog2(TIMEOUT+1).

Ports:
clk_i  input  1  system clock, rising edge.
rst_i  input  1  asynchronous, active-high reset.
start_i  input  1  start request; sampled only in IDLE.
mode_i  input  3  kem_mode_t {keygen, encap, decap}; must be one-hot.
abort_i  input  1  abandon the current operation.
mod_done_i  input  5  kem_module_t {trng, sampleA, sampleCBD_2k, ntt, hashG}; per-module done pulse or level.
mod_start_o  output  5  kem_module_t; one-hot start pulse to the active module.
ntt_mode_o  output  3  ntt_mode_t (NTT_a=0, NTT_b=1, PWM=2); valid while the NTT module is active.
idx_i_o  output  clog2(K)  row / polynomial index for the current run.
idx_j_o  output  clog2(K)  column index for the current run.
busy_o  output  1  high in every state except IDLE.
done_o  output  1  one-cycle pulse on successful completion.
err_o  output  1  one-cycle pulse on bad mode or timeout.

Behaviour:
- Reset: state=IDLE; all outputs 0; run counters 0; watchdog 0.
- States: IDLE, ISSUE, WAIT, DONE, ERR. A step register selects among TRNG, HASHG, SMPA, CBD, NTT, PWM.
- Step lists:
  - keygen: TRNG, HASHG, SMPA, CBD, NTT(2K runs), PWM.
  - encap: TRNG, HASHG, SMPA, CBD, NTT(K runs), PWM.
  - decap: HASHG, SMPA, CBD, NTT(K runs), PWM.
- Run counts per step:
  - TRNG, HASHG, CBD: 1 run each.
  - SMPA and PWM: K*K runs, j inner and i outer, so (0,0),(0,1),(1,0),(1,1) for K=2.
  - NTT run n: idx_i_o = n mod K; idx_j_o = n div K (0 for encap/decap).
- IDLE: start_i with one-hot mode_i latches the mode and goes to ISSUE at the first step. start_i with a non-one-hot mode_i (000, 011, 111, ...) goes to ERR. start_i while busy_o=1 is ignored.
- ISSUE, exactly one cycle:
  - mod_start_o = one-hot bit of the step's module; idx and ntt_mode_o are valid.
  - Watchdog cleared; next state WAIT.
- WAIT:
  - mod_start_o = 0; idx and ntt_mode_o stay stable.
  - Only the active module's mod_done_i bit is observed; other bits are ignored.
  - On done: advance the run or step and return to ISSUE, or go to DONE after the last PWM run.
  - done asserted in the ISSUE cycle is ignored; only WAIT-cycle done counts.
- ntt_mode_o: NTT_a during the NTT step, PWM during the PWM step, 0 otherwise. NTT_b is reserved for decap inverse use and is not issued.
- Watchdog: increments each WAIT cycle. Reaching TIMEOUT without done goes to ERR.
- DONE: done_o=1 for one cycle, then IDLE. ERR: err_o=1 for one cycle, then IDLE, with no done_o.
- abort_i in any non-IDLE state: IDLE next cycle; no done_o, no err_o. abort_i takes priority over done and timeout in the same cycle.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0.
- Latency with zero-wait modules (done the cycle after start): 2 cycles per run, plus 1 for DONE.
  - keygen: 15 runs, done_o 31 cycles after start_i is sampled.
  - encap: 13 runs, done_o at 27 cycles.
  - decap: 12 runs, done_o at 25 cycles.

Test Plan:
- keygen, every module done 1 cycle after its start: mod_start_o sequence is 10000, 00001, 01000 x4, 00100, 00010 x4, 00010 x4. idx for SMPA is (0,0),(0,1),(1,0),(1,1). NTT idx is (0,0),(1,0),(0,1),(1,1). done_o at cycle 31.
- encap and decap with a 3-cycle module latency: encap has 13 start pulses, decap has 12 with no TRNG pulse. busy_o stays high throughout, and done_o is a single pulse.
- mode_i=3'b011 with start_i: err_o pulses 1 cycle later, no mod_start_o, back to IDLE.
- TIMEOUT=16 and hashG never done: err_o pulses 16 WAIT cycles after the HASHG start; busy_o then falls.
- abort_i in the same cycle as the sampleA done on run 2: IDLE next cycle, no further mod_start_o, no done_o, no err_o. A new start_i then runs the full sequence.
- Spurious mod_done_i bits (ntt done during SMPA) are ignored. start_i pulses while busy are ignored. rst_i asserted mid-NTT clears all outputs immediately.

Source files
------------

// File: rtl/kem_seq_ctrl.sv
// kem_seq_ctrl: top-level ML-KEM sequencer.
// Takes a start request with a one-hot mode (keygen/encap/decap) and walks the
// shared engines (TRNG, hashG, sampleA, sampleCBD_2k, NTT) in a fixed order.
// For each run it issues a one-cycle start pulse and then waits for that
// engine's done. A watchdog bounds every wait.
// Ports:
//   clk_i, rst_i     clock; asynchronous active-high reset
//   start_i, mode_i  start request and one-hot mode {keygen, encap, decap}
//   abort_i          abandon the current operation and return to IDLE
//   mod_done_i       per-engine done {trng, sampleA, sampleCBD_2k, ntt, hashG}
//   mod_start_o      one-hot start pulse, same bit order as mod_done_i
//   ntt_mode_o       NTT sub-mode (NTT_a=0, NTT_b=1, PWM=2)
//   idx_i_o/idx_j_o  row / column index of the current run
//   busy_o, done_o, err_o  status; done_o and err_o are one-cycle pulses
module kem_seq_ctrl #(
  parameter int K       = 2,
  parameter int TIMEOUT = 4096,
  parameter int TO_W    = 13,
  localparam int IW     = (K > 1) ? $clog2(K) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [2:0]    mode_i,
  input  logic          abort_i,
  input  logic [4:0]    mod_done_i,
  output logic [4:0]    mod_start_o,
  output logic [2:0]    ntt_mode_o,
  output logic [IW-1:0] idx_i_o,
  output logic [IW-1:0] idx_j_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o
);

  localparam logic [4:0] M_TRNG  = 5'b10000;
  localparam logic [4:0] M_SMPA  = 5'b01000;
  localparam logic [4:0] M_CBD   = 5'b00100;
  localparam logic [4:0] M_NTT   = 5'b00010;
  localparam logic [4:0] M_HASHG = 5'b00001;

  localparam logic [2:0] MODE_KEYGEN = 3'b100;
  localparam logic [2:0] MODE_ENCAP  = 3'b010;
  localparam logic [2:0] MODE_DECAP  = 3'b001;

  // NTT_b (1) is reserved for inverse transforms and is never issued here.
  localparam logic [2:0] NTT_A   = 3'd0;
  localparam logic [2:0] NTT_PWM = 3'd2;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_ERR} state_t;
  typedef enum logic [2:0] {ST_TRNG, ST_HASHG, ST_SMPA, ST_CBD, ST_NTT, ST_PWM} step_t;

  state_t          state_q, state_d;
  step_t           step_q, step_d;
  logic [2:0]      mode_q, mode_d;
  logic [IW-1:0]   i_q, i_d, j_q, j_d;
  logic [TO_W-1:0] wdog_q, wdog_d;

  logic [4:0] mod_bit;
  logic       mod_done, last_i, last_j, ntt_last_j, mode_ok;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      step_q  <= ST_TRNG;
      mode_q  <= '0;
      i_q     <= '0;
      j_q     <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      mode_q  <= mode_d;
      i_q     <= i_d;
      j_q     <= j_d;
      wdog_q  <= wdog_d;
    end
  end

  always_comb begin
    mod_bit = '0;
    case (step_q)
      ST_TRNG:        mod_bit = M_TRNG;
      ST_HASHG:       mod_bit = M_HASHG;
      ST_SMPA:        mod_bit = M_SMPA;
      ST_CBD:         mod_bit = M_CBD;
      ST_NTT, ST_PWM: mod_bit = M_NTT;
      default:        mod_bit = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    mode_d  = mode_q;
    i_d     = i_q;
    j_d     = j_q;
    wdog_d  = wdog_q;

    // Only the active engine's done bit counts; stray bits are masked off.
    mod_done = |(mod_done_i & mod_bit);
    last_i   = (i_q == IW'(K - 1));
    last_j   = (j_q == IW'(K - 1));
    // keygen transforms 2K polynomials (j = 0,1); encap/decap only K (j = 0).
    ntt_last_j = (mode_q == MODE_KEYGEN) ? (j_q == IW'(1)) : 1'b1;
    mode_ok  = (mode_i == MODE_KEYGEN) || (mode_i == MODE_ENCAP) ||
               (mode_i == MODE_DECAP);

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (mode_ok) begin
            mode_d  = mode_i;
            step_d  = (mode_i == MODE_DECAP) ? ST_HASHG : ST_TRNG;
            state_d = S_ISSUE;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_ISSUE: begin
        wdog_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mod_done) begin
          state_d = S_ISSUE;
          case (step_q)
            ST_TRNG:  step_d = ST_HASHG;
            ST_HASHG: step_d = ST_SMPA;
            ST_CBD:   step_d = ST_NTT;
            // Matrix walks: j inner, i outer.
            ST_SMPA, ST_PWM: begin
              if (last_j) begin
                j_d = '0;
                if (last_i) begin
                  i_d = '0;
                  if (step_q == ST_SMPA) step_d = ST_CBD;
                  else                   state_d = S_DONE;
                end else begin
                  i_d = i_q + IW'(1);
                end
              end else begin
                j_d = j_q + IW'(1);
              end
            end
            // NTT run n: i = n mod K (inner), j = n div K (outer).
            ST_NTT: begin
              if (last_i) begin
                i_d = '0;
                if (ntt_last_j) begin
                  j_d    = '0;
                  step_d = ST_PWM;
                end else begin
                  j_d = j_q + IW'(1);
                end
              end else begin
                i_d = i_q + IW'(1);
              end
            end
            default: state_d = S_ERR;
          endcase
        end else if (wdog_q == TO_W'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th WAIT cycle without a done.
          state_d = S_ERR;
        end else begin
          wdog_d = wdog_q + TO_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort_i && (state_q != S_IDLE)) state_d = S_IDLE;

    // Leave the run bookkeeping clean whenever the sequence ends.
    if (state_d inside {S_IDLE, S_DONE, S_ERR}) begin
      step_d = ST_TRNG;
      i_d    = '0;
      j_d    = '0;
      wdog_d = '0;
    end
  end

  logic active;
  assign active      = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign busy_o      = (state_q != S_IDLE);
  assign mod_start_o = (state_q == S_ISSUE) ? mod_bit : 5'b0;
  assign ntt_mode_o  = (active && step_q == ST_PWM) ? NTT_PWM : NTT_A;
  assign idx_i_o     = i_q;
  assign idx_j_o     = j_q;
  assign done_o      = (state_q == S_DONE);
  assign err_o       = (state_q == S_ERR);

endmodule

// File: tb/tb_kem_seq_ctrl.sv
// Scoreboard bench for kem_seq_ctrl: expected start pulses are queued when a
// command is launched and popped as the DUT issues them.
module tb_kem_seq_ctrl;
  localparam int K = 2;

  logic       clk = 0;
  logic       rst_i, start_i, abort_i;
  logic [2:0] mode_i;
  logic [4:0] mod_done_i, mod_start_o;
  logic [2:0] ntt_mode_o;
  logic [0:0] idx_i_o, idx_j_o;
  logic       busy_o, done_o, err_o;

  kem_seq_ctrl #(.K(K), .TIMEOUT(16), .TO_W(5)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i),
    .abort_i(abort_i), .mod_done_i(mod_done_i), .mod_start_o(mod_start_o),
    .ntt_mode_o(ntt_mode_o), .idx_i_o(idx_i_o), .idx_j_o(idx_j_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o));

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] m;
    logic [0:0] i;
    logic [0:0] j;
    logic [2:0] nm;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_fail = 0;
  int   cyc = 0, t_launch = 0, t_start_last = 0;
  int   n_starts = 0, n_done = 0, n_err = 0;
  int   lat = 1;
  logic [4:0] hang = 0, cur_bit = 0, resp_done = 0;
  logic spur_en = 0;

  // Stray done bits on every engine except the one being waited on.
  assign mod_done_i = resp_done | (spur_en ? ~cur_bit : 5'b0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [4:0] m, input int i, input int j, input logic [2:0] nm);
    exp_t e;
    e.m = m; e.i = i[0:0]; e.j = j[0:0]; e.nm = nm;
    return e;
  endfunction

  // Expected start pulses for a mode, truncated to the first maxn entries.
  task automatic push_seq(input logic [2:0] m, input int maxn);
    exp_t l[$];
    int nr;
    if (m != 3'b001) l.push_back(mk(5'b10000, 0, 0, 0));
    l.push_back(mk(5'b00001, 0, 0, 0));
    for (int i = 0; i < K; i++) for (int j = 0; j < K; j++) l.push_back(mk(5'b01000, i, j, 0));
    l.push_back(mk(5'b00100, 0, 0, 0));
    nr = (m == 3'b100) ? 2 * K : K;
    for (int n = 0; n < nr; n++) l.push_back(mk(5'b00010, n % K, n / K, 0));
    for (int i = 0; i < K; i++) for (int j = 0; j < K; j++) l.push_back(mk(5'b00010, i, j, 2));
    for (int k = 0; k < l.size() && k < maxn; k++) sb.push_back(l[k]);
  endtask

  initial forever @(posedge clk) cyc++;

  // Engine model: answers each start with a done pulse lat cycles later.
  initial begin
    forever begin
      @(negedge clk);
      if (mod_start_o != 0) begin
        cur_bit = mod_start_o;
        if ((cur_bit & hang) == 0) begin
          repeat (lat) @(posedge clk);
          #1 resp_done = cur_bit;
          @(posedge clk);
          #1 resp_done = 0;
        end
      end
    end
  end

  // Monitor: pop scoreboard on every start pulse; count done/err pulses.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mod_start_o != 0) begin
        n_starts++;
        t_start_last = cyc;
        if (sb.size() == 0) chk("extra_start", mod_start_o, 0);
        else begin
          e = sb.pop_front();
          chk("start_mod", mod_start_o, e.m);
          chk("idx_i", idx_i_o, e.i);
          chk("idx_j", idx_j_o, e.j);
          chk("ntt_mode", ntt_mode_o, e.nm);
        end
      end
      if (done_o) n_done++;
      if (err_o)  n_err++;
    end
  end

  task automatic launch(input logic [2:0] m);
    @(negedge clk);
    start_i = 1; mode_i = m; t_launch = cyc;
    @(posedge clk);
    #1 start_i = 0; mode_i = 0;
  endtask

  // Wait (bounded) for done_o or err_o; count non-busy cycles before it.
  task automatic wait_end(input int bound, output int t_end, output bit got_done, output int gap);
    bit hit = 0;
    t_end = 0; got_done = 0; gap = 0;
    for (int k = 0; k < bound && !hit; k++) begin
      @(negedge clk);
      if (done_o || err_o) begin
        hit = 1; t_end = cyc; got_done = done_o;
      end else if (!busy_o) gap++;
    end
    chk("end_bound", hit, 1);
  endtask

  task automatic run_full(input string tg, input logic [2:0] m, input int l, input int runs, input bit poke);
    int d0, e0, s0, t_end, gap;
    bit got;
    push_seq(m, 999);
    lat = l; d0 = n_done; e0 = n_err; s0 = n_starts;
    launch(m);
    if (poke) fork
      begin
        repeat (8) @(negedge clk);
        start_i = 1; mode_i = 3'b100;
        @(negedge clk);
        start_i = 0; mode_i = 0;
      end
    join_none
    wait_end(400, t_end, got, gap);
    chk({tg, "_lat"}, t_end - t_launch, runs * (l + 1) + 1);
    chk({tg, "_done"}, got, 1);
    chk({tg, "_busy_gap"}, gap, 0);
    repeat (4) @(negedge clk);
    chk({tg, "_npulse"}, n_done - d0, 1);
    chk({tg, "_nerr"}, n_err - e0, 0);
    chk({tg, "_nstart"}, n_starts - s0, runs);
    chk({tg, "_sb"}, sb.size(), 0);
    chk({tg, "_idle"}, busy_o, 0);
  endtask

  task automatic run_bad(input string tg, input logic [2:0] m);
    int d0, e0, s0, t_end, gap;
    bit got;
    d0 = n_done; e0 = n_err; s0 = n_starts;
    launch(m);
    wait_end(10, t_end, got, gap);
    chk({tg, "_lat"}, t_end - t_launch, 1);
    chk({tg, "_is_err"}, got, 0);
    repeat (3) @(negedge clk);
    chk({tg, "_nerr"}, n_err - e0, 1);
    chk({tg, "_ndone"}, n_done - d0, 0);
    chk({tg, "_nstart"}, n_starts - s0, 0);
    chk({tg, "_idle"}, busy_o, 0);
  endtask

  task automatic wait_starts(input string tg, input int s0, input int n);
    bit hit = 0;
    for (int k = 0; k < 200 && !hit; k++) begin
      @(posedge clk);
      if (n_starts - s0 == n) hit = 1;
    end
    chk({tg, "_reach"}, hit, 1);
  endtask

  initial begin
    int d0, e0, s0, t_end, gap;
    bit got;
    rst_i = 1; start_i = 0; mode_i = 0; abort_i = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_start", mod_start_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_ntt", ntt_mode_o, 0);
    chk("rst_idx", {idx_i_o, idx_j_o}, 0);
    rst_i = 0;

    run_full("kg", 3'b100, 1, 15, 0);
    run_full("enc", 3'b010, 3, 13, 1);
    spur_en = 1;
    run_full("dec", 3'b001, 3, 12, 0);
    spur_en = 0;

    run_bad("bad011", 3'b011);
    run_bad("bad000", 3'b000);

    // hashG never answers: ERR after 16 WAIT cycles.
    hang = 5'b00001; lat = 1;
    push_seq(3'b010, 2);
    d0 = n_done; e0 = n_err; s0 = n_starts;
    launch(3'b010);
    wait_end(100, t_end, got, gap);
    chk("to_is_err", got, 0);
    chk("to_lat", t_end - t_start_last, 17);
    repeat (3) @(negedge clk);
    chk("to_nerr", n_err - e0, 1);
    chk("to_ndone", n_done - d0, 0);
    chk("to_nstart", n_starts - s0, 2);
    chk("to_sb", sb.size(), 0);
    chk("to_idle", busy_o, 0);
    hang = 0;
    repeat (3) @(negedge clk);

    // Abort in the same cycle as the second sampleA done.
    push_seq(3'b100, 4);
    lat = 1; d0 = n_done; e0 = n_err; s0 = n_starts;
    launch(3'b100);
    wait_starts("ab", s0, 4);
    #1 abort_i = 1;
    @(posedge clk);
    #1 abort_i = 0;
    @(negedge clk);
    chk("ab_busy", busy_o, 0);
    chk("ab_start", mod_start_o, 0);
    repeat (10) @(negedge clk);
    chk("ab_ndone", n_done - d0, 0);
    chk("ab_nerr", n_err - e0, 0);
    chk("ab_nstart", n_starts - s0, 4);
    chk("ab_sb", sb.size(), 0);
    run_full("kg2", 3'b100, 1, 15, 0);

    // Reset asserted during the second NTT run (idx_i = 1).
    push_seq(3'b100, 9);
    lat = 1; d0 = n_done; e0 = n_err; s0 = n_starts;
    launch(3'b100);
    wait_starts("rm", s0, 9);
    #1 rst_i = 1;
    #1;
    chk("rm_busy", busy_o, 0);
    chk("rm_start", mod_start_o, 0);
    chk("rm_idx", {idx_i_o, idx_j_o}, 0);
    chk("rm_ntt", ntt_mode_o, 0);
    chk("rm_flags", {done_o, err_o}, 0);
    @(posedge clk);
    #1 rst_i = 0;
    repeat (5) @(negedge clk);
    chk("rm_nstart", n_starts - s0, 9);
    chk("rm_ndone", n_done - d0, 0);
    chk("rm_nerr", n_err - e0, 0);
    chk("rm_sb", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: sim reached %0t without finishing", $time);
    $fatal(1, "global timeout");
  end
endmodule
